// File: rtl/soc_system_box_cmd.sv
// soc_system_box_cmd: HPS-to-fabric command mailbox.
// An Avalon-MM slave pushes entries into a small FIFO; the fabric drains it
// over a valid/ready stream. STATUS, CTRL and DROPS registers share the slave.
module soc_system_box_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic                  overflow_reg;
  logic                  enable_reg;
  logic [15:0]           drop_cnt_reg;
  logic [31:0]           readdata_next;

  logic wr;
  logic empty;
  logic full;
  logic push_req;
  logic push_ok;
  logic push_drop;
  logic flush;
  logic pop;
  logic unused_wdata;

  // Upper writedata bits are only partly decoded; fold them so lint sees them consumed.
  assign unused_wdata = ^writedata;

  assign wr        = chipselect & ~write_n;
  assign empty     = (level_reg == '0);
  assign full      = (level_reg == FULL_LVL);
  assign push_req  = wr && (address == 2'd0);
  // Full is judged on the pre-edge level, so a same-cycle pop cannot make room.
  assign push_ok   = push_req && !full;
  assign push_drop = push_req && full;
  assign flush     = wr && (address == 2'd2) && writedata[1];
  // Flush beats a same-cycle pop.
  assign pop       = out_valid && out_ready && !flush;

  assign out_valid = !empty && enable_reg;
  // Head is forced to zero while empty so stale storage never leaks out.
  assign out_port  = empty ? '0 : mem[rd_ptr_reg];

  // FIFO storage: written only by accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Pointers and fill level; flush and reset both return to an empty FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Control and status: enable, sticky overflow and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (wr && (address == 2'd2)) enable_reg <= writedata[0];
      if (push_drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end else begin
        if (wr && (address == 2'd1) && writedata[2]) overflow_reg <= 1'b0;
        if (wr && (address == 2'd3)) drop_cnt_reg <= '0;
      end
    end
  end

  // Read mux over pre-edge register state; reads never have side effects.
  always_comb begin
    readdata_next = '0;
    case (address)
      2'd0: readdata_next[DATA_WIDTH-1:0] = out_port;
      2'd1: begin
        readdata_next[0]          = empty;
        readdata_next[1]          = full;
        readdata_next[2]          = overflow_reg;
        readdata_next[8 +: LVL_W] = level_reg;
      end
      2'd2:    readdata_next[0]    = enable_reg;
      default: readdata_next[15:0] = drop_cnt_reg;
    endcase
  end

  // Registered read data, one cycle after the address is presented.
  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= readdata_next;
  end

endmodule
